// File: rtl/sid_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_reg_pkg
// Description : Shared constants and types for the SID register interface.
//               Contains the voice and filter register addresses, the
//               wav_ctrl and mode_vol bit positions, and the layout of the
//               combined 16-bit host bus {ui_in, uio_in}.
// Revision    : 1.0 - initial release
// ============================================================================
package sid_reg_pkg;

  // Voice register addresses (voices 0..2)
  localparam logic [2:0] FREQ_LO  = 3'd0;
  localparam logic [2:0] FREQ_HI  = 3'd1;
  localparam logic [2:0] PW_LO    = 3'd2;
  localparam logic [2:0] PW_HI    = 3'd3;
  localparam logic [2:0] ATK      = 3'd4;
  localparam logic [2:0] SUS      = 3'd5;
  localparam logic [2:0] WAV      = 3'd6;

  // Filter register addresses (voice select 3)
  localparam logic [2:0] FC_LO    = 3'd0;
  localparam logic [2:0] FC_HI    = 3'd1;
  localparam logic [2:0] RES_FILT = 3'd2;
  localparam logic [2:0] MODE_VOL = 3'd3;
  localparam logic [1:0] VOICE_FILT = 2'd3;

  // wav_ctrl bit positions
  localparam int unsigned WAV_NOISE = 7;
  localparam int unsigned WAV_PULSE = 6;
  localparam int unsigned WAV_SAW   = 5;
  localparam int unsigned WAV_TRI   = 4;
  localparam int unsigned WAV_TEST  = 3;
  localparam int unsigned WAV_RING  = 2;
  localparam int unsigned WAV_SYNC  = 1;
  localparam int unsigned WAV_GATE  = 0;

  // mode_vol bit positions
  localparam int unsigned MV_V3OFF  = 7;
  localparam int unsigned MV_HP     = 6;
  localparam int unsigned MV_BP     = 5;
  localparam int unsigned MV_LP     = 4;

  // Combined host bus: ui_in in the upper byte, uio_in in the lower byte
  localparam int unsigned BUS_WIDTH = 16;
  localparam int unsigned BUS_STB   = 15;

  typedef struct packed {
    logic       stb;
    logic [1:0] rsvd;
    logic [1:0] voice;
    logic [2:0] addr;
    logic [7:0] data;
  } sid_bus_t;

endpackage
`default_nettype wire

// File: rtl/sid_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sid_sync_edge
// Description : Multi-stage synchronizer for the whole host bus plus a
//               rising-edge detector on the synchronized write strobe.
//               Strobe and payload share one flop chain so they stay aligned.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   bus_i     in  raw asynchronous bus
//   bus_o     out synchronized bus (aligned with wr_edge_o)
//   wr_edge_o out one-cycle pulse on a synchronized strobe rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sid_sync_edge #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned STB_IDX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             wr_edge_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  // vld_q tracks which stages hold real samples taken after reset, so that
  // the reset-cleared zeros are never mistaken for a low strobe.
  logic [STAGES-1:0]            vld_q;
  logic                         s_prev_q;
  // armed_q: a genuine low strobe has been seen since reset. Keeps a strobe
  // that was already high at reset release from producing a write.
  logic                         armed_q;
  logic                         s_last;

  assign s_last = sync_q[STAGES-1][STB_IDX];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      vld_q    <= '0;
      s_prev_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], bus_i};
      vld_q    <= {vld_q[STAGES-2:0], 1'b1};
      s_prev_q <= s_last;
      if (vld_q[STAGES-1] && !s_last) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign bus_o     = sync_q[STAGES-1];
  assign wr_edge_o = s_last & ~s_prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/sid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : sid_reg_if
// Description : Write-only register-bus responder for the SID core. Decodes
//               the synchronized host write and updates the three voice
//               register sets and the filter registers, presented as flat
//               parallel outputs.
//   clk, rst           clock, synchronous active-high reset
//   bus_in             ui_in: [7] strobe, [6:5] reserved, [4:3] voice, [2:0] addr
//   data_in            uio_in write data
//   freq/pw/atk_dcy/sus_rel/wav_ctrl   per-voice fields, voice v in slice v
//   fc/res_filt/mode_vol               filter fields
//   wr_pulse/wr_voice/wr_addr          commit flag and last write location
// Revision    : 1.0 - initial release
// ============================================================================
module sid_reg_if
  import sid_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bus_in,
  input  logic [7:0]  data_in,
  output logic [47:0] freq,
  output logic [35:0] pw,
  output logic [23:0] atk_dcy,
  output logic [23:0] sus_rel,
  output logic [23:0] wav_ctrl,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  output logic        wr_pulse,
  output logic [1:0]  wr_voice,
  output logic [2:0]  wr_addr
);

  logic [BUS_WIDTH-1:0] bus_sync;
  sid_bus_t             bus_s;
  logic                 wr_edge;
  logic                 unused_rsvd;

  sid_sync_edge #(
    .WIDTH   (BUS_WIDTH),
    .STAGES  (SYNC_STAGES),
    .STB_IDX (BUS_STB)
  ) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .bus_i     ({bus_in, data_in}),
    .bus_o     (bus_sync),
    .wr_edge_o (wr_edge)
  );

  assign bus_s       = bus_sync;
  assign unused_rsvd = ^{bus_s.rsvd, bus_s.stb};

  logic [2:0][15:0] freq_q, freq_d;
  logic [2:0][11:0] pw_q,   pw_d;
  logic [2:0][7:0]  atk_q,  atk_d;
  logic [2:0][7:0]  sus_q,  sus_d;
  logic [2:0][7:0]  wav_q,  wav_d;
  logic [10:0]      fc_q,   fc_d;
  logic [7:0]       res_q,  res_d;
  logic [7:0]       mv_q,   mv_d;
  logic             wr_pulse_q, wr_pulse_d;
  logic [1:0]       wr_voice_q, wr_voice_d;
  logic [2:0]       wr_addr_q,  wr_addr_d;

  always_comb begin
    freq_d     = freq_q;
    pw_d       = pw_q;
    atk_d      = atk_q;
    sus_d      = sus_q;
    wav_d      = wav_q;
    fc_d       = fc_q;
    res_d      = res_q;
    mv_d       = mv_q;
    wr_pulse_d = wr_edge;
    wr_voice_d = wr_voice_q;
    wr_addr_d  = wr_addr_q;

    if (wr_edge) begin
      // Location is recorded even for unmapped addresses.
      wr_voice_d = bus_s.voice;
      wr_addr_d  = bus_s.addr;
      if (bus_s.voice == VOICE_FILT) begin
        case (bus_s.addr)
          FC_LO:    fc_d[2:0]  = bus_s.data[2:0];
          FC_HI:    fc_d[10:3] = bus_s.data;
          RES_FILT: res_d      = bus_s.data;
          MODE_VOL: mv_d       = bus_s.data;
          default:  ;
        endcase
      end else begin
        case (bus_s.addr)
          FREQ_LO:  freq_d[bus_s.voice][7:0]  = bus_s.data;
          FREQ_HI:  freq_d[bus_s.voice][15:8] = bus_s.data;
          PW_LO:    pw_d[bus_s.voice][7:0]    = bus_s.data;
          PW_HI:    pw_d[bus_s.voice][11:8]   = bus_s.data[3:0];
          ATK:      atk_d[bus_s.voice]        = bus_s.data;
          SUS:      sus_d[bus_s.voice]        = bus_s.data;
          WAV:      wav_d[bus_s.voice]        = bus_s.data;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_q     <= '0;
      pw_q       <= '0;
      atk_q      <= '0;
      sus_q      <= '0;
      wav_q      <= '0;
      fc_q       <= '0;
      res_q      <= '0;
      mv_q       <= '0;
      wr_pulse_q <= 1'b0;
      wr_voice_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      freq_q     <= freq_d;
      pw_q       <= pw_d;
      atk_q      <= atk_d;
      sus_q      <= sus_d;
      wav_q      <= wav_d;
      fc_q       <= fc_d;
      res_q      <= res_d;
      mv_q       <= mv_d;
      wr_pulse_q <= wr_pulse_d;
      wr_voice_q <= wr_voice_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign freq     = freq_q;
  assign pw       = pw_q;
  assign atk_dcy  = atk_q;
  assign sus_rel  = sus_q;
  assign wav_ctrl = wav_q;
  assign fc       = fc_q;
  assign res_filt = res_q;
  assign mode_vol = mv_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_voice = wr_voice_q;
  assign wr_addr  = wr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_sid_reg_if
// Description : Self-checking bench for sid_reg_if. Expected commits
//               (voice, address, commit edge) are queued when a strobe is
//               driven and checked against wr_pulse/wr_voice/wr_addr by a
//               monitor; register contents are checked against constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_reg_if;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 41;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bus_in;
  logic [7:0]  data_in;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] atk_dcy, sus_rel, wav_ctrl;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic        wr_pulse;
  logic [1:0]  wr_voice;
  logic [2:0]  wr_addr;

  sid_reg_if #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .data_in  (data_in),
    .freq     (freq),
    .pw       (pw),
    .atk_dcy  (atk_dcy),
    .sus_rel  (sus_rel),
    .wav_ctrl (wav_ctrl),
    .fc       (fc),
    .res_filt (res_filt),
    .mode_vol (mode_vol),
    .wr_pulse (wr_pulse),
    .wr_voice (wr_voice),
    .wr_addr  (wr_addr)
  );

  always #HALF clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [1:0] v;
    logic [2:0] a;
    int         e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Commit monitor: every wr_pulse must match the head of the scoreboard,
  // on exactly the predicted edge; a head whose edge passes with no pulse
  // is reported as missed.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (wr_pulse) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 48'(wr_pulse), 48'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_edge", 48'(edge_cnt), 48'(e.e));
          check("wr_voice", 48'(wr_voice), 48'(e.v));
          check("wr_addr", 48'(wr_addr), 48'(e.a));
        end
      end else if (sb.size() > 0 && edge_cnt >= sb[0].e) begin
        e = sb.pop_front();
        check("missed_pulse", 48'(wr_pulse), 48'd1);
      end
    end
  end

  task automatic drive(input logic stb, input logic [1:0] v, input logic [2:0] a,
                       input logic [7:0] d, input logic [1:0] rsvd = 2'b00);
    bus_in  = {stb, rsvd, v, a};
    data_in = d;
  endtask

  task automatic expect_commit(input logic [1:0] v, input logic [2:0] a);
    exp_t e;
    e.v = v;
    e.a = a;
    e.e = edge_cnt + 1 + SYNC_STAGES;
    sb.push_back(e);
  endtask

  // Setup cycle, strobe high for hi cycles, then one low cycle.
  task automatic host_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                            input int hi = 1, input logic [1:0] rsvd = 2'b00);
    @(negedge clk); drive(1'b0, v, a, d, rsvd);
    @(negedge clk); drive(1'b1, v, a, d, rsvd); expect_commit(v, a);
    repeat (hi) @(negedge clk);
    drive(1'b0, v, a, d, rsvd);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 48'(sb.size()), 48'd0);
  endtask

  logic [47:0] s_freq;
  logic [35:0] s_pw;
  logic [23:0] s_atk, s_sus, s_wav;
  logic [10:0] s_fc;
  logic [7:0]  s_res, s_mv;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 3'd0, 8'h00);
    repeat (50) @(negedge clk);
    check("rst_freq", freq, 48'd0);
    check("rst_pw", 48'(pw), 48'd0);
    check("rst_atk", 48'(atk_dcy), 48'd0);
    check("rst_sus", 48'(sus_rel), 48'd0);
    check("rst_wav", 48'(wav_ctrl), 48'd0);
    check("rst_fc", 48'(fc), 48'd0);
    check("rst_res", 48'(res_filt), 48'd0);
    check("rst_mv", 48'(mode_vol), 48'd0);
    check("rst_wr_pulse", 48'(wr_pulse), 48'd0);
    check("rst_wr_voice", 48'(wr_voice), 48'd0);
    check("rst_wr_addr", 48'(wr_addr), 48'd0);

    // Strobe already high when reset releases: must not write.
    drive(1'b1, 2'd0, 3'd6, 8'h21);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("held_rst_wav", 48'(wav_ctrl), 48'd0);
    drive(1'b0, 2'd0, 3'd6, 8'h21);
    repeat (5) @(negedge clk);
    check("held_rst_wav_after_low", 48'(wav_ctrl), 48'd0);

    // Voice 0 frequency with explicit latency check.
    host_write(2'd0, 3'd0, 8'hD6);
    check("freq_lo_before_commit", 48'(freq[15:0]), 48'h0000);
    @(negedge clk);
    check("freq_lo_at_commit", 48'(freq[15:0]), 48'h00D6);
    host_write(2'd0, 3'd1, 8'h1C);
    check("freq_hi_before_commit", 48'(freq[15:0]), 48'h00D6);
    @(negedge clk);
    check("freq_v0", 48'(freq[15:0]), 48'h1CD6);
    check("freq_v12", 48'(freq[47:16]), 48'd0);
    drain();

    // Filter registers; second mode write sets the reserved bus bits.
    host_write(2'd3, 3'd3, 8'h4F);
    drain();
    check("mode_vol_1", 48'(mode_vol), 48'h4F);
    host_write(2'd3, 3'd3, 8'h2F, 1, 2'b11);
    drain();
    check("mode_vol_2", 48'(mode_vol), 48'h2F);
    host_write(2'd3, 3'd0, 8'hFF);
    host_write(2'd3, 3'd1, 8'h20);
    drain();
    check("fc", 48'(fc), 48'h107);
    host_write(2'd2, 3'd3, 8'hF8);
    drain();
    check("pw_v2", 48'(pw[35:24]), 48'h800);
    check("pw_v01", 48'(pw[23:0]), 48'd0);

    // Long strobe: exactly one commit.
    host_write(2'd1, 3'd6, 8'h41, 20);
    drain();
    repeat (5) @(negedge clk);
    check("wav_v1", 48'(wav_ctrl[15:8]), 48'h41);
    check("wav_v02", 48'({wav_ctrl[23:16], wav_ctrl[7:0]}), 48'd0);

    // Unmapped addresses: pulse and location update, no register change.
    s_freq = freq; s_pw = pw; s_atk = atk_dcy; s_sus = sus_rel;
    s_wav = wav_ctrl; s_fc = fc; s_res = res_filt; s_mv = mode_vol;
    host_write(2'd0, 3'd7, 8'hFF);
    drain();
    check("ign_wr_voice_0", 48'(wr_voice), 48'd0);
    check("ign_wr_addr_7", 48'(wr_addr), 48'd7);
    host_write(2'd3, 3'd5, 8'hFF);
    drain();
    check("ign_wr_voice_3", 48'(wr_voice), 48'd3);
    check("ign_wr_addr_5", 48'(wr_addr), 48'd5);
    check("ign_freq", freq, s_freq);
    check("ign_pw", 48'(pw), 48'(s_pw));
    check("ign_atk", 48'(atk_dcy), 48'(s_atk));
    check("ign_sus", 48'(sus_rel), 48'(s_sus));
    check("ign_wav", 48'(wav_ctrl), 48'(s_wav));
    check("ign_fc", 48'(fc), 48'(s_fc));
    check("ign_res", 48'(res_filt), 48'(s_res));
    check("ign_mv", 48'(mode_vol), 48'(s_mv));

    // Minimum spacing: strobe 1 high / 1 low, address and data change with it.
    begin
      logic [7:0] d[4];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h34;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); drive(1'b1, 2'd1, 3'(i), d[i]); expect_commit(2'd1, 3'(i));
        @(negedge clk); drive(1'b0, 2'd1, 3'(i), d[i]);
      end
    end
    drain();
    check("min_freq_v1", 48'(freq[31:16]), 48'h2211);
    check("min_pw_v1", 48'(pw[23:12]), 48'h433);
    check("min_freq_v0", 48'(freq[15:0]), 48'h1CD6);

    repeat (10) @(negedge clk);
    check("sb_empty_end", 48'(sb.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(2 * HALF * 5000);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sid_reg_if.md
# sid_reg_if

Register-bus responder for the SID core. It receives the host's strobed write protocol on the `ui_in`/`uio_in` pins, synchronizes and edge-detects the write strobe, and decodes voice and address. It updates the register bank for three voices and the filter, then presents every field as flat parallel outputs to the oscillators, envelopes and filter. It sits between the top-level pin wrapper and the synthesis datapath.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for the strobe and bus (legal values ≥2).
- `clk  in  1` — system clock, 12 MHz.
- `rst  in  1` — reset; synchronous, active-high.
- `bus_in  in  8` — `ui_in`: bit7 is the write strobe, bits6:5 are reserved (ignored), bits4:3 are the voice select, bits2:0 are the address.
- `data_in  in  8` — `uio_in` write data.
- `freq  out  48` — voice v freq at [16v+15:16v]; lo byte is addr 0, hi byte is addr 1.
- `pw  out  36` — voice v pulse width at [12v+11:12v]; addr 2 is bits 7:0, addr 3 bits 3:0 are bits 11:8.
- `atk_dcy  out  24` — addr 4 per voice; attack is [7:4], decay is [3:0].
- `sus_rel  out  24` — addr 5 per voice; sustain is [7:4], release is [3:0].
- `wav_ctrl  out  24` — addr 6 per voice; bits are noise 7, pulse 6, saw 5, tri 4, test 3, ring 2, sync 1, gate 0.
- `fc  out  11` — filter cutoff; addr 0 bits 2:0 are bits 2:0, addr 1 is bits 10:3.
- `res_filt  out  8` — addr 2; resonance is [7:4], route enables V0..V2 are [2:0], ext is [3].
- `mode_vol  out  8` — addr 3; v3off is 7, HP 6, BP 5, LP 4, volume is [3:0].
- `wr_pulse  out  1` — one-cycle flag, asserted on the cycle a write commits.
- `wr_voice  out  2`, `wr_addr  out  3` — voice and address of the last committed write.

## Operation
- The full 16-bit bus (`bus_in`, `data_in`) passes through a `SYNC_STAGES`-deep flop chain. The strobe and the address/data share the chain, so they stay aligned.
- Rising-edge detect: `s_last & ~s_prev`, where `s_prev` is one extra flop on the synchronized strobe.
- On a detected edge, decode the synchronized voice and address and write the synchronized data.
  - Voices 0–2: addresses 0–6 are valid. Address 7 is ignored (no state change), but `wr_pulse` still fires.
  - Voice 3 (filter): addresses 0–3 are valid. Addresses 4–7 are ignored, but `wr_pulse` still fires.
  - Partial registers store only their defined bits: PW_HI keeps [3:0] and FC_LO keeps [2:0]. Undefined bits always read 0.
- A strobe held high for any number of cycles produces exactly one write.
- No read-back; the block is write-only.

## Timing
- Reset: every output and every sync/edge flop is 0, including `wr_pulse`, `wr_voice` and `wr_addr`. An all-zero `wav_ctrl` means gate is off.
- Reset mid-write flushes the synchronizer. A strobe already high when reset releases does not write until it goes low and then high again.
- Latency: the strobe is first sampled high at edge k. The register value and `wr_pulse` become visible after edge k+`SYNC_STAGES`. `wr_pulse` is high for exactly that one cycle.
- Host rules:
  - Strobe high for ≥1 clk and low for ≥1 clk between writes.
  - Address and data stable from one clk before the strobe rises until ≥`SYNC_STAGES` clk after it rises. The 3-cycle host write task satisfies this at the default depth.
- Writes are never dropped or merged when the spacing rules are met. Back-to-back writes commit in order, 2 clk apart at minimum.

## Structure
- Package `sid_reg_pkg` holds:
  - voice address constants: FREQ_LO 0, FREQ_HI 1, PW_LO 2, PW_HI 3, ATK 4, SUS 5, WAV 6;
  - filter address constants: FC_LO 0, FC_HI 1, RES_FILT 2, MODE_VOL 3, and VOICE_FILT = 3;
  - `wav_ctrl` bit indices and `mode_vol` bit indices.
- Sub-module `sid_sync_edge`, parameterized by `WIDTH` and `STAGES`: the bus synchronizer plus strobe rising-edge detector. It outputs the aligned bus and a one-cycle `wr_edge`.

## Test plan
- Reset: hold `rst` for 50 clk → all outputs 0. A strobe held high through reset release, with voice 0 addr 6 and data 0x21 on the bus → `wav_ctrl` stays 0 and no `wr_pulse`.
- Voice 0 writes FREQ_LO 0xD6 then FREQ_HI 0x1C → `freq[15:0]` = 0x1CD6 exactly `SYNC_STAGES` edges after each strobe's first-high edge. Voices 1 and 2 stay 0 and `wr_pulse` fires twice.
- Filter writes MODE_VOL 0x4F, then 0x2F → `mode_vol` = 0x4F, then 0x2F. FC_LO 0xFF, FC_HI 0x20 → `fc` = 0x107. PW_HI 0xF8 to voice 2 → `pw[35:24]` = 0x800.
- Strobe held high for 20 clk with WAV 0x41 to voice 1 → exactly one `wr_pulse`, and `wav_ctrl[15:8]` = 0x41.
- Ignored addresses: voice 0 addr 7 data 0xFF, and filter addr 5 data 0xFF → `wr_pulse` fires, `wr_addr` updates, and all register outputs are unchanged.
- Minimum spacing: strobe 1 high / 1 low, with 4 consecutive writes to voice 1 addresses 0–3 → all four commit in order, and `freq`/`pw` for voice 1 match the written data.
